program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Parameters
REQ-001 SHALL have parameter PC_W, default 10, program counter width in bits.
REQ-002 SHALL have parameter IMM_W, default 8, signed branch offset width (IMM_W <= PC_W).
REQ-003 SHALL have parameter NUM_PROGS, default 4, number of selectable programs; SEL_W = max(1, clog2(NUM_PROGS)).
REQ-004 SHALL have parameter PROG_SHIFT, default 7; program k entry address = k << PROG_SHIFT, truncated to PC_W.
REQ-005 SHALL have parameter MAX_CYCLES, default 4096, watchdog limit in RUN cycles; CNT_W = clog2(MAX_CYCLES+1).

Interface
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  testbench request; a high-then-low sequence launches a program.
REQ-009 prog_sel  in  SEL_W  program index, sampled on the start rising edge.
REQ-010 done  in  1  decoded halt instruction at current pc.
REQ-011 branch_en  in  1  decoded branch instruction at current pc.
REQ-012 zero  in  1  ALU branch condition.
REQ-013 imm  in  IMM_W  signed branch offset.
REQ-014 stall  in  1  hold pc for this cycle.
REQ-015 pc  out  PC_W  current instruction address.
REQ-016 run_en  out  1  high only in RUN; gates register/memory writes (decoder sees NOP when low).
REQ-017 ack  out  1  program finished or timed out; level signal.
REQ-018 timeout  out  1  qualifies ack: run ended by watchdog.
REQ-019 cycle_count  out  CNT_W  RUN cycles consumed by current/last run.

Function
REQ-020 SHALL implement states IDLE, ARMED, RUN, FINISH.
REQ-021 IDLE/FINISH: start=1 -> ARMED; latch prog_sel; pc <= entry(prog_sel); cycle_count <= 0; ack <= 0; timeout <= 0.
REQ-022 ARMED: remain while start=1; start=0 -> RUN; pc, cycle_count held.
REQ-023 prog_sel >= NUM_PROGS SHALL select entry 0.
REQ-024 RUN: run_en=1; cycle_count increments by 1 every RUN cycle, stall included.
REQ-025 RUN, done=1 -> FINISH, pc held, ack <= 1, timeout <= 0; done takes priority over branch, stall and watchdog.
REQ-026 RUN, no done, stall=1 -> pc held.
REQ-027 RUN, no done/stall, branch_en=1 and zero=1 -> pc <= pc + 1 + sign_extend(imm), modulo 2^PC_W.
REQ-028 RUN otherwise -> pc <= pc + 1, modulo 2^PC_W (wraps to 0 from all-ones).
REQ-029 RUN, no done, cycle_count = MAX_CYCLES-1 -> FINISH, ack <= 1, timeout <= 1; cycle_count reaches MAX_CYCLES and saturates.
REQ-030 FINISH: ack, timeout, pc, cycle_count held until start=1 (REQ-021); run_en=0.
REQ-031 start changes during RUN SHALL be ignored.
REQ-032 ack and timeout SHALL be registered outputs; run_en SHALL be decoded from state only.

Reset
REQ-033 reset=1 at a clock edge SHALL force IDLE, pc=0, ack=0, timeout=0, cycle_count=0, run_en=0, from any state, including mid-RUN.
REQ-034 reset SHALL take priority over every other input in the same cycle.

Verification
REQ-035 Defaults: reset; start=1 for 2 cycles, prog_sel=2; start=0 -> pc=256 in RUN; 5 plain cycles -> pc=261; done=1 -> next cycle ack=1, timeout=0, cycle_count=6, pc=261.
REQ-036 Branch: at pc=20 branch_en=1, zero=1, imm=8'hFB (-5) -> pc=16; same with zero=0 -> pc=21; pc=1023 plain -> pc=0.
REQ-037 Watchdog: MAX_CYCLES=16, done never asserted -> after 16 RUN cycles ack=1, timeout=1, cycle_count=16; done=1 on the 16th cycle instead -> ack=1, timeout=0.
REQ-038 Stall: stall=1 for 3 cycles at pc=40 -> pc stays 40, cycle_count +3; stall and done same cycle -> FINISH.
REQ-039 Restart/reset: after ack, start=1, prog_sel=1 -> ack=0, pc=128; reset asserted mid-RUN -> next cycle IDLE, all outputs 0; prog_sel=5 with NUM_PROGS=4 -> pc=0.

Source files
------------

// File: rtl/program_sequencer.sv
// Program sequencer: selects a program entry, steps the PC through it with
// branch/stall support, and ends the run on a halt instruction or watchdog expiry.
module program_sequencer #(
    parameter int PC_W       = 10,
    parameter int IMM_W      = 8,
    parameter int NUM_PROGS  = 4,
    parameter int PROG_SHIFT = 7,
    parameter int MAX_CYCLES = 4096,
    localparam int SEL_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
    localparam int CNT_W     = $clog2(MAX_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SEL_W-1:0] prog_sel,
    input  logic             done,
    input  logic             branch_en,
    input  logic             zero,
    input  logic [IMM_W-1:0] imm,
    input  logic             stall,
    output logic [PC_W-1:0]  pc,
    output logic             run_en,
    output logic             ack,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    // state  | meaning
    // IDLE   | out of reset, waiting for start
    // ARMED  | program latched, waiting for start to drop
    // RUN    | executing; pc advances, watchdog counts
    // FINISH | halted or timed out; results held until next start
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             tmo_q, tmo_d;

    logic [PC_W-1:0]  entry;
    logic [PC_W-1:0]  imm_ext;

    assign imm_ext = PC_W'($signed(imm));

    // Out-of-range program indices fall back to program 0.
    always_comb begin
        entry = '0;
        if (32'(prog_sel) < NUM_PROGS) begin
            entry = PC_W'(prog_sel) << PROG_SHIFT;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE, FINISH: begin
                if (start) begin
                    state_d = ARMED;
                    pc_d    = entry;
                    cnt_d   = '0;
                    ack_d   = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            ARMED: begin
                if (!start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (done) begin
                    state_d = FINISH;
                    ack_d   = 1'b1;
                    tmo_d   = 1'b0;
                end else begin
                    if (stall) begin
                        pc_d = pc_q;
                    end else if (branch_en && zero) begin
                        pc_d = pc_q + PC_W'(1) + imm_ext;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = FINISH;
                        ack_d   = 1'b1;
                        tmo_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            tmo_q   <= tmo_d;
        end
    end

    assign pc          = pc_q;
    assign run_en      = (state_q == RUN);
    assign ack         = ack_q;
    assign timeout     = tmo_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: a default-parameter instance plus a
// short-watchdog instance with five programs for timeout and out-of-range select.
module tb_program_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  prog_sel;
    logic [2:0]  w_prog_sel;
    logic        done;
    logic        branch_en;
    logic        zero;
    logic [7:0]  imm;
    logic        stall;

    logic [9:0]  d_pc;
    logic        d_run_en;
    logic        d_ack;
    logic        d_timeout;
    logic [12:0] d_cc;

    logic [9:0]  w_pc;
    logic        w_run_en;
    logic        w_ack;
    logic        w_timeout;
    logic [4:0]  w_cc;

    int checks;
    int failures;

    program_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel),
        .done(done), .branch_en(branch_en), .zero(zero), .imm(imm),
        .stall(stall), .pc(d_pc), .run_en(d_run_en), .ack(d_ack),
        .timeout(d_timeout), .cycle_count(d_cc)
    );

    program_sequencer #(.NUM_PROGS(5), .MAX_CYCLES(16)) dut_wd (
        .clk(clk), .reset(reset), .start(start), .prog_sel(w_prog_sel),
        .done(done), .branch_en(branch_en), .zero(zero), .imm(imm),
        .stall(stall), .pc(w_pc), .run_en(w_run_en), .ack(w_ack),
        .timeout(w_timeout), .cycle_count(w_cc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; start = 1'b0; prog_sel = 2'd0; w_prog_sel = 3'd0;
        done = 1'b0; branch_en = 1'b0; zero = 1'b0; imm = 8'h00; stall = 1'b0;
        tick(2);
        reset = 1'b0;
        chk("rst_pc", d_pc, 0);
        chk("rst_ack", d_ack, 0);
        chk("rst_timeout", d_timeout, 0);
        chk("rst_cc", d_cc, 0);
        chk("rst_run_en", d_run_en, 0);

        // basic run of program 2
        start = 1'b1; prog_sel = 2'd2;
        tick(2);
        chk("armed_run_en", d_run_en, 0);
        chk("armed_pc", d_pc, 256);
        start = 1'b0;
        tick(1);
        chk("run_entry_run_en", d_run_en, 1);
        chk("run_entry_pc", d_pc, 256);
        tick(5);
        chk("plain5_pc", d_pc, 261);
        chk("plain5_cc", d_cc, 5);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        chk("done_ack", d_ack, 1);
        chk("done_timeout", d_timeout, 0);
        chk("done_cc", d_cc, 6);
        chk("done_pc", d_pc, 261);
        chk("done_run_en", d_run_en, 0);
        tick(2);
        chk("finish_hold_pc", d_pc, 261);
        chk("finish_hold_ack", d_ack, 1);

        // restart with program 1, then reset mid-RUN alongside done
        start = 1'b1; prog_sel = 2'd1;
        tick(1);
        chk("restart_ack", d_ack, 0);
        chk("restart_pc", d_pc, 128);
        chk("restart_cc", d_cc, 0);
        start = 1'b0;
        tick(3);
        chk("restart_run_pc", d_pc, 130);
        chk("restart_run_en", d_run_en, 1);
        reset = 1'b1; done = 1'b1;
        tick(1);
        reset = 1'b0; done = 1'b0;
        chk("midrun_rst_pc", d_pc, 0);
        chk("midrun_rst_ack", d_ack, 0);
        chk("midrun_rst_timeout", d_timeout, 0);
        chk("midrun_rst_cc", d_cc, 0);
        chk("midrun_rst_run_en", d_run_en, 0);
        tick(1);
        chk("idle_stays_run_en", d_run_en, 0);

        // branches, ignored start, stall, stall+done
        start = 1'b1; prog_sel = 2'd0;
        tick(1);
        start = 1'b0;
        tick(1);
        tick(20);
        chk("pc20", d_pc, 20);
        branch_en = 1'b1; zero = 1'b1; imm = 8'hFB;
        tick(1);
        chk("branch_neg_pc", d_pc, 16);
        branch_en = 1'b0;
        tick(4);
        branch_en = 1'b1; zero = 1'b0;
        tick(1);
        chk("branch_nottaken_pc", d_pc, 21);
        zero = 1'b1; imm = 8'h05; start = 1'b1;
        tick(1);
        chk("branch_pos_pc", d_pc, 27);
        chk("start_ignored_run_en", d_run_en, 1);
        start = 1'b0; branch_en = 1'b0; zero = 1'b0;
        tick(13);
        chk("pc40", d_pc, 40);
        chk("cc40", d_cc, 40);
        stall = 1'b1;
        tick(3);
        chk("stall_pc", d_pc, 40);
        chk("stall_cc", d_cc, 43);
        done = 1'b1;
        tick(1);
        stall = 1'b0; done = 1'b0;
        chk("stall_done_ack", d_ack, 1);
        chk("stall_done_pc", d_pc, 40);
        chk("stall_done_cc", d_cc, 44);
        chk("stall_done_run_en", d_run_en, 0);

        // pc wrap from all-ones
        start = 1'b1; prog_sel = 2'd3;
        tick(1);
        chk("prog3_pc", d_pc, 384);
        start = 1'b0;
        tick(1);
        tick(639);
        chk("pc1023", d_pc, 1023);
        tick(1);
        chk("wrap_pc", d_pc, 0);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        chk("wrap_done_ack", d_ack, 1);

        // watchdog and out-of-range select on the small instance
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        start = 1'b1; w_prog_sel = 3'd5;
        tick(1);
        chk("oor_sel_pc", w_pc, 0);
        start = 1'b0;
        tick(1);
        tick(15);
        chk("wd15_ack", w_ack, 0);
        chk("wd15_cc", w_cc, 15);
        tick(1);
        chk("wd_ack", w_ack, 1);
        chk("wd_timeout", w_timeout, 1);
        chk("wd_cc", w_cc, 16);
        chk("wd_run_en", w_run_en, 0);
        tick(2);
        chk("wd_hold_cc", w_cc, 16);
        start = 1'b1; w_prog_sel = 3'd4;
        tick(1);
        chk("wd_restart_pc", w_pc, 512);
        chk("wd_restart_timeout", w_timeout, 0);
        chk("wd_restart_cc", w_cc, 0);
        start = 1'b0;
        tick(1);
        tick(15);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        chk("wd_done16_ack", w_ack, 1);
        chk("wd_done16_timeout", w_timeout, 0);
        chk("wd_done16_cc", w_cc, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
